// File: rtl/ball_motion_if.sv
// ball_motion_if: groups the frame/button inputs and the position/status outputs of the ball controller.
interface ball_motion_if;
  logic       frame_tick;
  logic       launch;
  logic       pause;
  logic [9:0] xPos;
  logic [9:0] yPos;
  logic       moving;
  logic       wall_hit;

  modport master (
    output frame_tick, launch, pause,
    input  xPos, yPos, moving, wall_hit
  );

  modport slave (
    input  frame_tick, launch, pause,
    output xPos, yPos, moving, wall_hit
  );
endinterface

// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: advances the ball centre once per frame, bouncing off the active-area walls.
// Optional RANDOM_LAUNCH_EN: launch direction is taken from a free-running 4-bit LFSR.
module ball_motion_ctrl #(
  parameter int H_MIN   = 144,
  parameter int H_MAX   = 783,
  parameter int V_MIN   = 31,
  parameter int V_MAX   = 510,
  parameter int RADIUS  = 8,
  parameter int X_START = 464,
  parameter int Y_START = 271,
  parameter int X_SPEED = 2,
  parameter int Y_SPEED = 2
) (
  input  logic         clk,
  input  logic         rst,
  ball_motion_if.slave bus
);
  // state    | meaning
  // S_IDLE   | parked at start position, waiting for launch
  // S_MOVE   | position advances on every frame_tick
  // S_PAUSED | position held while pause is high
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MOVE   = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  // Clamp limits are the wall coordinates pulled in by the ball radius.
  localparam logic [10:0] X_LO = 11'(H_MIN + RADIUS);
  localparam logic [10:0] X_HI = 11'(H_MAX - RADIUS);
  localparam logic [10:0] Y_LO = 11'(V_MIN + RADIUS);
  localparam logic [10:0] Y_HI = 11'(V_MAX - RADIUS);
  localparam logic [10:0] X_SP = 11'(X_SPEED);
  localparam logic [10:0] Y_SP = 11'(Y_SPEED);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic        r_dir_x;
  logic        r_dir_y;
  logic        r_moving;
  logic        r_wall_hit;
  logic [10:0] w_nx;
  logic [10:0] w_ny;
  logic [9:0]  w_x_nxt;
  logic [9:0]  w_y_nxt;
  logic        w_dir_x_nxt;
  logic        w_dir_y_nxt;
  logic        w_hit_x;
  logic        w_hit_y;
  logic        w_launch_dx;
  logic        w_launch_dy;
  logic        w_do_launch;
  logic        w_do_step;

`ifdef RANDOM_LAUNCH_EN
  logic [3:0] r_lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_lfsr <= 4'b1001;
    else     r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
  end

  assign w_launch_dx = r_lfsr[0];
  assign w_launch_dy = r_lfsr[1];
`else
  assign w_launch_dx = 1'b1;
  assign w_launch_dy = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.launch) w_state_nxt = S_MOVE;
      S_MOVE:   if (bus.pause)  w_state_nxt = S_PAUSED;
      S_PAUSED: if (!bus.pause) w_state_nxt = S_MOVE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign w_do_launch = (r_state == S_IDLE) && bus.launch;
  assign w_do_step   = (r_state == S_MOVE) && bus.frame_tick;

  always_comb begin
    w_nx        = r_dir_x ? ({1'b0, r_x} + X_SP) : ({1'b0, r_x} - X_SP);
    w_ny        = r_dir_y ? ({1'b0, r_y} + Y_SP) : ({1'b0, r_y} - Y_SP);
    w_x_nxt     = w_nx[9:0];
    w_y_nxt     = w_ny[9:0];
    w_dir_x_nxt = r_dir_x;
    w_dir_y_nxt = r_dir_y;
    w_hit_x     = 1'b0;
    w_hit_y     = 1'b0;
    if (r_dir_x && (w_nx > X_HI)) begin
      w_x_nxt     = X_HI[9:0];
      w_dir_x_nxt = 1'b0;
      w_hit_x     = 1'b1;
    end else if (!r_dir_x && (w_nx < X_LO)) begin
      w_x_nxt     = X_LO[9:0];
      w_dir_x_nxt = 1'b1;
      w_hit_x     = 1'b1;
    end
    if (r_dir_y && (w_ny > Y_HI)) begin
      w_y_nxt     = Y_HI[9:0];
      w_dir_y_nxt = 1'b0;
      w_hit_y     = 1'b1;
    end else if (!r_dir_y && (w_ny < Y_LO)) begin
      w_y_nxt     = Y_LO[9:0];
      w_dir_y_nxt = 1'b1;
      w_hit_y     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_x        <= 10'(X_START);
      r_y        <= 10'(Y_START);
      r_dir_x    <= 1'b1;
      r_dir_y    <= 1'b1;
      r_moving   <= 1'b0;
      r_wall_hit <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_moving   <= (w_state_nxt == S_MOVE);
      r_wall_hit <= 1'b0;
      if (w_do_launch) begin
        r_dir_x <= w_launch_dx;
        r_dir_y <= w_launch_dy;
      end
      if (w_do_step) begin
        r_x        <= w_x_nxt;
        r_y        <= w_y_nxt;
        r_dir_x    <= w_dir_x_nxt;
        r_dir_y    <= w_dir_y_nxt;
        r_wall_hit <= w_hit_x | w_hit_y;
      end
    end
  end

  assign bus.xPos     = r_x;
  assign bus.yPos     = r_y;
  assign bus.moving   = r_moving;
  assign bus.wall_hit = r_wall_hit;
endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb_ball_motion_ctrl: vector table, directed corner sequences and random stimulus against a frame-level model.
module tb_ball_motion_ctrl;
  logic clk;
  logic rst;
  ball_motion_if bus();

  ball_motion_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: plain integer position and signed direction per axis.
  int       mx, my, dx, dy;
  bit       m_launched, m_moving, m_hit;
  bit [3:0] m_lfsr;

  typedef struct packed {
    bit t;
    bit l;
    bit p;
    int x;
    int y;
    bit mv;
    bit hit;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_x"},   int'(bus.xPos),     mx);
    check({tag, "_y"},   int'(bus.yPos),     my);
    check({tag, "_mv"},  int'(bus.moving),   int'(m_moving));
    check({tag, "_hit"}, int'(bus.wall_hit), int'(m_hit));
  endtask

  task automatic model_reset();
    mx = 464; my = 271; dx = 1; dy = 1;
    m_launched = 0; m_moving = 0; m_hit = 0;
    m_lfsr = 4'b1001;
  endtask

  task automatic model_step(input bit t, input bit l, input bit p);
    int nx, ny;
    m_hit = 0;
    if (m_moving && t) begin
      nx = mx + 2 * dx;
      ny = my + 2 * dy;
      if (dx > 0 && nx + 8 > 783)      begin mx = 775; dx = -1; m_hit = 1; end
      else if (dx < 0 && nx < 144 + 8) begin mx = 152; dx = 1;  m_hit = 1; end
      else mx = nx;
      if (dy > 0 && ny + 8 > 510)      begin my = 502; dy = -1; m_hit = 1; end
      else if (dy < 0 && ny < 31 + 8)  begin my = 39;  dy = 1;  m_hit = 1; end
      else my = ny;
    end
    if (!m_launched) begin
      if (l) begin
        m_launched = 1;
        m_moving   = 1;
`ifdef RANDOM_LAUNCH_EN
        dx = m_lfsr[0] ? 1 : -1;
        dy = m_lfsr[1] ? 1 : -1;
`else
        dx = 1;
        dy = 1;
`endif
      end
    end else begin
      m_moving = !p;
    end
    m_lfsr = {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
  endtask

  task automatic step(input bit t, input bit l, input bit p);
    bus.frame_tick = t;
    bus.launch     = l;
    bus.pause      = p;
    model_step(t, l, p);
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
    bus.launch     = 1'b0;
    check_model("cyc");
  endtask

  task automatic do_reset();
    bus.frame_tick = 1'b0;
    bus.launch     = 1'b0;
    bus.pause      = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_model("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit pz;
    rst = 1'b1;
    bus.frame_tick = 1'b0;
    bus.launch     = 1'b0;
    bus.pause      = 1'b0;
    model_reset();

    vecs[0] = '{t: 0, l: 1, p: 0, x: 464, y: 271, mv: 1, hit: 0};
    vecs[1] = '{t: 1, l: 0, p: 0, x: 466, y: 273, mv: 1, hit: 0};
    vecs[2] = '{t: 0, l: 0, p: 1, x: 466, y: 273, mv: 0, hit: 0};
    vecs[3] = '{t: 1, l: 0, p: 1, x: 466, y: 273, mv: 0, hit: 0};
    vecs[4] = '{t: 1, l: 1, p: 0, x: 466, y: 273, mv: 1, hit: 0};
    vecs[5] = '{t: 1, l: 0, p: 1, x: 468, y: 275, mv: 0, hit: 0};
    vecs[6] = '{t: 0, l: 0, p: 0, x: 468, y: 275, mv: 1, hit: 0};
    vecs[7] = '{t: 1, l: 0, p: 0, x: 470, y: 277, mv: 1, hit: 0};

    repeat (2) @(posedge clk);
    do_reset();

`ifndef RANDOM_LAUNCH_EN
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].t, vecs[i].l, vecs[i].p);
      check("vec_x",   int'(bus.xPos),     vecs[i].x);
      check("vec_y",   int'(bus.yPos),     vecs[i].y);
      check("vec_mv",  int'(bus.moving),   int'(vecs[i].mv));
      check("vec_hit", int'(bus.wall_hit), int'(vecs[i].hit));
    end

    // Reset mid-motion, then ticks must not move the parked ball.
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    do_reset();
    check("rst_mid_x",  int'(bus.xPos),   464);
    check("rst_mid_y",  int'(bus.yPos),   271);
    check("rst_mid_mv", int'(bus.moving), 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    check("idle_x", int'(bus.xPos), 464);
    check("idle_y", int'(bus.yPos), 271);

    // Launch and first tick.
    do_reset();
    step(0, 1, 0);
    step(1, 0, 0);
    check("t2_x",   int'(bus.xPos),     466);
    check("t2_y",   int'(bus.yPos),     273);
    check("t2_mv",  int'(bus.moving),   1);
    check("t2_hit", int'(bus.wall_hit), 0);

    // Bottom wall bounce on tick 116.
    do_reset();
    step(0, 1, 0);
    for (int i = 0; i < 115; i++) step(1, 0, 0);
    step(1, 0, 0);
    check("bnc_x",   int'(bus.xPos),     696);
    check("bnc_y",   int'(bus.yPos),     502);
    check("bnc_hit", int'(bus.wall_hit), 1);
    step(0, 0, 0);
    check("bnc_hit_clr", int'(bus.wall_hit), 0);
    step(1, 0, 0);
    check("bnc2_x", int'(bus.xPos), 698);
    check("bnc2_y", int'(bus.yPos), 500);

    // Pause for 20 ticks, then resume.
    step(0, 0, 1);
    for (int i = 0; i < 20; i++) step(1, 0, 1);
    check("pz_x",  int'(bus.xPos),   698);
    check("pz_y",  int'(bus.yPos),   500);
    check("pz_mv", int'(bus.moving), 0);
    step(0, 0, 0);
    step(1, 0, 0);
    check("res_x", int'(bus.xPos), 700);
    check("res_y", int'(bus.yPos), 498);

    // Launch and pause together in IDLE.
    do_reset();
    step(0, 1, 1);
    check("lp_mv1", int'(bus.moving), 1);
    step(0, 0, 1);
    check("lp_mv2", int'(bus.moving), 0);
    check("lp_x",   int'(bus.xPos),   464);
    check("lp_y",   int'(bus.yPos),   271);
`else
    // LFSR is 4'b0110 when launch is sampled on the third edge after reset.
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    check("rl_x", int'(bus.xPos), 462);
    check("rl_y", int'(bus.yPos), 273);
`endif

    // Random stimulus against the model.
    do_reset();
    pz = 0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 15) == 0) pz = ~pz;
      if ($urandom_range(0, 1999) == 0) begin
        do_reset();
        pz = 0;
      end
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 40) == 0), pz);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
